game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller that sequences the 4-bit LFSR random source and schedules obstacle spawns for the playfield. It owns the game state machine (idle/play/paused/over), drives the LFSR's reset/pause/gameover controls, divides the system clock into game ticks, and issues spawn requests carrying an LFSR-derived column over a valid/ready handshake. It also tracks score and difficulty level, which shortens the spawn interval.

## Interface
- TICK_DIV, 3200: clocks per game tick.
- COLS, 16: playfield columns; power of two, 2..16.
- SPAWN_BASE, 8: ticks between spawns at level 0.
- LEVEL_STEP, 16: accepted spawns per level increment.
- MAX_LEVEL, 7: level saturation value (< SPAWN_BASE).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock domain.
- start_btn  in  1  start request (level, pre-synchronised).
- pause_btn  in  1  pause toggle (level, pre-synchronised).
- collision  in  1  playfield collision flag.
- rnd  in  4  LFSR output.
- lfsr_reset  out  1  to LFSR reset.
- lfsr_pause  out  1  to LFSR pause.
- lfsr_gameover  out  1  to LFSR gameover.
- spawn_valid  out  1  spawn request pending.
- spawn_col  out  $clog2(COLS)  spawn column.
- spawn_ready  in  1  playfield accepts spawn.
- tick  out  1  one-cycle game-tick pulse.
- score  out  8  accepted spawns, saturating at 255.
- level  out  3  difficulty level.
- state  out  2  game_state_e.

## Operation
- Edge pulses: start_e = start_btn & ~start_q, pause_e = pause_btn & ~pause_q; *_q registered every cycle, including during reset.
- FSM states: IDLE, PLAY, PAUSED, OVER. IDLE: start_e -> PLAY, clearing score, level, tick/spawn counters, pending spawn. PLAY: collision -> OVER (beats pause_e); else pause_e -> PAUSED. PAUSED: pause_e -> PLAY; collision ignored. OVER: start_e -> IDLE.
- LFSR controls (combinational from state): lfsr_reset = IDLE, lfsr_pause = PAUSED, lfsr_gameover = OVER.
- Tick counter runs only in PLAY, 0..TICK_DIV-1; tick = 1 on wrap. Frozen (not cleared) in PAUSED.
- Spawn timer counts ticks; interval = SPAWN_BASE - level. On reaching interval with nothing pending: pending set, spawn_col latched from rnd[$clog2(COLS)-1:0], timer cleared. Timer halts while pending; no queuing, no drops.
- spawn_valid = pending & (state == PLAY). spawn_col stable while pending; a pending spawn is withheld in PAUSED and re-presented unchanged on resume.
- Accept on spawn_valid & spawn_ready: pending cleared, score +1 (saturate), level-step counter +1; at LEVEL_STEP it clears and level +1 (saturate MAX_LEVEL).
- Collision to OVER clears pending in the same edge.

## Timing
- Reset values: state IDLE, spawn_valid 0, spawn_col 0, score 0, level 0, tick 0, lfsr_reset 1, lfsr_pause 0, lfsr_gameover 0.
- State changes on the first clk edge with the button sampled high after low; holding the button gives one transition.
- First tick: TICK_DIV cycles after entering PLAY. spawn_valid rises the cycle after the interval-th tick.
- Accept takes effect on the same edge; a new spawn requires a full new interval.
- Reset has priority over all events. start_e and pause_e together in IDLE -> PLAY.

## Configuration
- SPAWN_NO_REPEAT_EN defined: if the latched column equals the last accepted column, (col+1) mod COLS is used instead. Last-accepted register reset to 0 and cleared on game start.
- Undefined: raw LFSR column, no extra register.

## Structure
- game_pkg: game_state_e (IDLE=0, PLAY=1, PAUSED=2, OVER=3), score/level widths, default parameter constants.
- Sub-module edge_detect (registered rising-edge pulse), instantiated for start_btn and pause_btn.

## Test plan
(TICK_DIV=4, SPAWN_BASE=3, LEVEL_STEP=2, MAX_LEVEL=2, COLS=16)
- Reset, hold start high 10 cycles -> single IDLE->PLAY; lfsr_reset 1->0; tick every 4 cycles.
- rnd=4'hA, spawn_ready=0 -> spawn_valid after the 3rd tick, spawn_col=10 held stable for 20 cycles while rnd changes; ready=1 -> score=1, valid drops the next cycle.
- 2 accepts -> level=1, interval 2 ticks; 4 accepts -> level=2; 6 accepts -> level stays 2.
- Pending spawn, pause_e -> PAUSED, valid=0, lfsr_pause=1, counters frozen; pause_e -> valid returns with the same column.
- collision and pause_e in the same PLAY cycle -> OVER, lfsr_gameover=1, pending cleared; start_e -> IDLE, then start_e -> PLAY with score=0.
- SPAWN_NO_REPEAT_EN: two consecutive spawns with rnd=5 -> columns 5 then 6.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, output widths and default parameters for
// the game sequencer slice.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } game_state_e;

  localparam int SCORE_W = 8;
  localparam int LEVEL_W = 3;

  localparam int DEF_TICK_DIV   = 3200;
  localparam int DEF_COLS       = 16;
  localparam int DEF_SPAWN_BASE = 8;
  localparam int DEF_LEVEL_STEP = 16;
  localparam int DEF_MAX_LEVEL  = 7;

  // Saturating score increment (sticks at all-ones).
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: spawn request handshake between sequencer (master) and
// playfield (slave).
interface game_sequencer_if #(
  parameter int COL_W = 4
) ();
  logic             spawn_valid;
  logic [COL_W-1:0] spawn_col;
  logic             spawn_ready;

  modport master (output spawn_valid, output spawn_col, input  spawn_ready);
  modport slave  (input  spawn_valid, input  spawn_col, output spawn_ready);
endinterface

// File: rtl/game_sequencer_edge_detect.sv
// edge_detect: rising-edge pulse against the previous-cycle sample. The
// history register has no reset so it keeps tracking the button while the
// rest of the design is held in reset; a button held through reset release
// therefore does not fire.
module edge_detect (
  input  logic clk,
  input  logic din,
  output logic pulse
);
  logic q;

  // Previous-cycle sample of the input.
  always_ff @(posedge clk) q <= din;

  assign pulse = din & ~q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game FSM, LFSR control, tick divider, spawn scheduler,
// score and difficulty level.
// Optional build macro SPAWN_NO_REPEAT_EN: avoid spawning in the same column
// as the last accepted spawn by bumping to the next column.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int COLS       = DEF_COLS,
  parameter int SPAWN_BASE = DEF_SPAWN_BASE,
  parameter int LEVEL_STEP = DEF_LEVEL_STEP,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                collision,
  input  logic [3:0]          rnd,
  output logic                lfsr_reset,
  output logic                lfsr_pause,
  output logic                lfsr_gameover,
  game_sequencer_if.master    spawn,
  output logic                tick,
  output logic [SCORE_W-1:0]  score,
  output logic [LEVEL_W-1:0]  level,
  output game_state_e         state
);

  localparam int COL_W = $clog2(COLS);
  localparam int TCW   = $clog2(TICK_DIV + 1);
  localparam int SCW   = $clog2(SPAWN_BASE + 1);
  localparam int LSW   = $clog2(LEVEL_STEP + 1);

  game_state_e        state_q, state_nx;
  logic               start_e, pause_e;
  logic [TCW-1:0]     tcnt;
  logic               tick_q;
  logic [SCW-1:0]     stimer;
  logic [SCW-1:0]     interval;
  logic               pending;
  logic [COL_W-1:0]   col_q, raw_col, new_col;
  logic [SCORE_W-1:0] score_q;
  logic [LEVEL_W-1:0] level_q;
  logic [LSW-1:0]     lstep;
  logic               game_start, run, accept, tick_play, spawn_due;

  edge_detect u_start_ed (.clk(clk), .din(start_btn), .pulse(start_e));
  edge_detect u_pause_ed (.clk(clk), .din(pause_btn), .pulse(pause_e));

  // Next state plus state-decoded outputs.
  always_comb begin
    state_nx          = state_q;
    lfsr_reset        = 1'b0;
    lfsr_pause        = 1'b0;
    lfsr_gameover     = 1'b0;
    spawn.spawn_valid = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_reset = 1'b1;
        if (start_e) state_nx = PLAY;
      end
      PLAY: begin
        spawn.spawn_valid = pending;
        if (collision)    state_nx = OVER;
        else if (pause_e) state_nx = PAUSED;
      end
      PAUSED: begin
        lfsr_pause = 1'b1;
        if (pause_e) state_nx = PLAY;
      end
      OVER: begin
        lfsr_gameover = 1'b1;
        if (start_e) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign game_start = (state_q == IDLE) & start_e;
  // The divider only advances while staying in PLAY, so a tick is never
  // emitted into PAUSED/OVER and the count is frozen across a pause.
  assign run        = (state_q == PLAY) & (state_nx == PLAY);
  assign accept     = spawn.spawn_valid & spawn.spawn_ready;
  assign tick_play  = tick_q & (state_q == PLAY) & ~pending;
  assign interval   = SCW'(SPAWN_BASE) - SCW'(level_q);
  assign spawn_due  = tick_play & (SCW'(stimer + 1'b1) == interval);
  assign raw_col    = rnd[COL_W-1:0];

`ifdef SPAWN_NO_REPEAT_EN
  logic [COL_W-1:0] last_col;

  // Column of the last accepted spawn; wraps naturally since COLS is 2^n.
  always_ff @(posedge clk) begin
    if (reset || game_start) last_col <= '0;
    else if (accept)         last_col <= col_q;
  end

  assign new_col = (raw_col == last_col) ? raw_col + 1'b1 : raw_col;
`else
  assign new_col = raw_col;
`endif

  // Game state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  // Clock divider producing the registered one-cycle tick.
  always_ff @(posedge clk) begin
    if (reset || game_start) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= run && (tcnt == TCW'(TICK_DIV - 1));
      if (run) tcnt <= (tcnt == TCW'(TICK_DIV - 1)) ? '0 : tcnt + 1'b1;
    end
  end

  // Spawn timer and single-entry pending slot; timer halts while pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      stimer  <= '0;
      col_q   <= '0;
    end else if (game_start) begin
      pending <= 1'b0;
      stimer  <= '0;
    end else if ((state_q == PLAY) && collision) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending <= 1'b0;
    end else if (spawn_due) begin
      pending <= 1'b1;
      col_q   <= new_col;
      stimer  <= '0;
    end else if (tick_play) begin
      stimer  <= stimer + 1'b1;
    end
  end

  // Score and difficulty level advance on each accepted spawn.
  always_ff @(posedge clk) begin
    if (reset || game_start) begin
      score_q <= '0;
      level_q <= '0;
      lstep   <= '0;
    end else if (accept) begin
      score_q <= score_inc(score_q);
      if (lstep == LSW'(LEVEL_STEP - 1)) begin
        lstep <= '0;
        if (level_q != LEVEL_W'(MAX_LEVEL)) level_q <= level_q + 1'b1;
      end else begin
        lstep <= lstep + 1'b1;
      end
    end
  end

  assign spawn.spawn_col = col_q;
  assign tick            = tick_q;
  assign score           = score_q;
  assign level           = level_q;
  assign state           = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer with a
// small configuration (TICK_DIV=4, SPAWN_BASE=3, LEVEL_STEP=2, MAX_LEVEL=2).
module tb_game_sequencer;
  import game_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int COLS       = 16;
  localparam int SPAWN_BASE = 3;
  localparam int LEVEL_STEP = 2;
  localparam int MAX_LEVEL  = 2;
`ifdef SPAWN_NO_REPEAT_EN
  localparam bit NO_REP = 1'b1;
`else
  localparam bit NO_REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start_btn, pause_btn, collision;
  logic [3:0]  rnd;
  logic        lfsr_reset, lfsr_pause, lfsr_gameover, tick;
  logic [7:0]  score;
  logic [2:0]  level;
  game_state_e state;

  game_sequencer_if #(.COL_W(4)) sif ();

  game_sequencer #(
    .TICK_DIV(TICK_DIV), .COLS(COLS), .SPAWN_BASE(SPAWN_BASE),
    .LEVEL_STEP(LEVEL_STEP), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .collision(collision), .rnd(rnd), .lfsr_reset(lfsr_reset),
    .lfsr_pause(lfsr_pause), .lfsr_gameover(lfsr_gameover), .spawn(sif),
    .tick(tick), .score(score), .level(level), .state(state)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_total = 0;
  int         nt;
  logic [3:0] last_col, exp_col;
  logic [2:0] lvl_tab [1:6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] adj(input logic [3:0] raw, input logic [3:0] last);
    return (NO_REP && raw == last) ? raw + 4'd1 : raw;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count ticks seen until spawn_valid rises (bounded).
  task automatic wait_valid(output int n);
    int cyc;
    n = 0;
    cyc = 0;
    while (!sif.spawn_valid && cyc < 200) begin
      if (tick) n++;
      step(1);
      cyc++;
    end
    chk("valid_timeout", 32'(sif.spawn_valid), 32'd1);
  endtask

  task automatic accept_measure(input int i, input logic [2:0] exp_lvl);
    sif.spawn_ready = 1'b1;
    step(1);
    sif.spawn_ready = 1'b0;
    chk("acc_valid_drop", 32'(sif.spawn_valid), 32'd0);
    chk("acc_score", 32'(score), 32'(i));
    chk("acc_level", 32'(level), 32'(exp_lvl));
    last_col = exp_col;
    exp_col  = adj(rnd, last_col);
    wait_valid(nt);
    chk("interval_ticks", 32'(nt), 32'(SPAWN_BASE - int'(exp_lvl)));
    chk("spawn_col", 32'(sif.spawn_col), 32'(exp_col));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; collision = 1'b0;
    rnd = 4'hA; sif.spawn_ready = 1'b0;
    last_col = 4'd0;
    step(3);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_valid", 32'(sif.spawn_valid), 32'd0);
    chk("rst_col", 32'(sif.spawn_col), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_lfsr_reset", 32'(lfsr_reset), 32'd1);
    chk("rst_lfsr_pause", 32'(lfsr_pause), 32'd0);
    chk("rst_lfsr_gameover", 32'(lfsr_gameover), 32'd0);

    reset = 1'b0;
    step(1);
    chk("idle_hold", 32'(state), 32'(IDLE));

    // Start held 10 cycles: one transition, ticks every 4, spawn after 3 ticks.
    start_btn = 1'b1;
    step(1);
    chk("start_play", 32'(state), 32'(PLAY));
    chk("start_lfsr_reset", 32'(lfsr_reset), 32'd0);
    exp_col = adj(4'hA, last_col);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      chk("hold_state", 32'(state), 32'(PLAY));
      chk("tick_phase", 32'(tick), 32'((k % 4) == 0));
      chk("first_valid", 32'(sif.spawn_valid), 32'(k == 13));
      if (k == 9) start_btn = 1'b0;
    end
    chk("first_col", 32'(sif.spawn_col), 32'hA);

    // Column held while rnd churns and ready stays low.
    for (int k = 0; k < 20; k++) begin
      rnd = 4'(k * 3 + 1);
      step(1);
      chk("held_valid", 32'(sif.spawn_valid), 32'd1);
      chk("held_col", 32'(sif.spawn_col), 32'hA);
    end
    rnd = 4'hA;

    // Six accepts: level 0,1,1,2,2,2 with interval SPAWN_BASE-level.
    for (int i = 1; i <= 6; i++) accept_measure(i, lvl_tab[i]);

    // Pause with a pending spawn; tick divider sits at 1 on entry.
    pause_btn = 1'b1;
    step(1);
    chk("pause_state", 32'(state), 32'(PAUSED));
    chk("pause_valid", 32'(sif.spawn_valid), 32'd0);
    chk("pause_lfsr", 32'(lfsr_pause), 32'd1);
    pause_btn = 1'b0; rnd = 4'h3; collision = 1'b1;
    step(1);
    chk("pause_collision_ignored", 32'(state), 32'(PAUSED));
    collision = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("pause_tick", 32'(tick), 32'd0);
      chk("pause_valid_hold", 32'(sif.spawn_valid), 32'd0);
    end
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
    chk("resume_state", 32'(state), 32'(PLAY));
    chk("resume_valid", 32'(sif.spawn_valid), 32'd1);
    chk("resume_col", 32'(sif.spawn_col), 32'(exp_col));
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("resume_tick", 32'(tick), 32'(k == 3));
    end

    // Collision beats pause in the same cycle.
    collision = 1'b1; pause_btn = 1'b1;
    step(1);
    collision = 1'b0; pause_btn = 1'b0;
    chk("over_state", 32'(state), 32'(OVER));
    chk("over_gameover", 32'(lfsr_gameover), 32'd1);
    chk("over_pause", 32'(lfsr_pause), 32'd0);
    chk("over_valid", 32'(sif.spawn_valid), 32'd0);

    start_btn = 1'b1;
    step(1);
    chk("over_to_idle", 32'(state), 32'(IDLE));
    chk("idle_lfsr_reset", 32'(lfsr_reset), 32'd1);
    step(1);
    chk("idle_held_btn", 32'(state), 32'(IDLE));
    start_btn = 1'b0; rnd = 4'h5;
    step(1);
    start_btn = 1'b1; pause_btn = 1'b1;
    step(1);
    start_btn = 1'b0; pause_btn = 1'b0;
    chk("restart_state", 32'(state), 32'(PLAY));
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_valid", 32'(sif.spawn_valid), 32'd0);

    // Two spawns with rnd=5: 5 then 6 with no-repeat, else 5 then 5.
    last_col = 4'd0;
    exp_col  = adj(4'h5, last_col);
    wait_valid(nt);
    chk("restart_interval", 32'(nt), 32'd3);
    chk("restart_col", 32'(sif.spawn_col), 32'h5);
    accept_measure(1, 3'd0);
    chk("second_col", 32'(sif.spawn_col), NO_REP ? 32'h6 : 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
